mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Initiator-side controller for the combinational 5-way muxed-A fixed-point MAC unit (A×B+C, TC-selectable).
- Accepts one dot-product job: N_TAPS A operands, N_TAPS B operands, a bias and a TC flag.
- Sequences the MAC one tap per cycle, feeding the MAC sum back as the next C operand.
- Returns the final sum over a valid/ready handshake. Sits between a job source (filter or array controller) and the MAC datapath.

Parameters:
- A_width, 8, width of each A operand.
- B_width, 8, width of each B operand.
- SUM_width, 22, accumulator / MAC sum width.
- N_TAPS, 5, taps per job; legal range 1..5, matching the MAC's 5-entry select mux.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  job request.
- in_ready  out  1  sequencer can accept a job.
- in_A  in  A_width*N_TAPS  packed A operands, tap k at [A_width*k +: A_width].
- in_B  in  B_width*N_TAPS  packed B operands, tap k at [B_width*k +: B_width].
- in_bias  in  SUM_width  initial accumulator value.
- in_TC  in  1  1 = two's complement, 0 = unsigned.
- mac_select  out  3  tap index to the MAC A-mux.
- mac_A  out  A_width*5  latched packed A to the MAC; taps at and above N_TAPS driven 0.
- mac_B  out  B_width  B operand of the current tap.
- mac_C  out  SUM_width  current accumulator.
- mac_TC  out  1  latched TC.
- mac_SUM  in  SUM_width  MAC result, combinational function of mac_* outputs.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  SUM_width  final dot-product result.

Behaviour:
- Reset values: all outputs 0 except in_ready=1; state IDLE, idx=0, acc=0.
- State IDLE
  - in_ready=1; mac_select=0, mac_B=0, mac_C=0.
  - On in_valid: latch in_A, in_B, in_TC; set acc<=in_bias, idx<=0; go to RUN.
- State RUN
  - in_ready=0.
  - mac_select=idx, mac_B=B[idx], mac_C=acc, mac_TC=TC_latched.
  - Each cycle: acc<=mac_SUM, idx<=idx+1.
  - When idx==N_TAPS-1: out_sum<=mac_SUM, out_valid<=1, go to DONE.
- State DONE
  - out_valid=1; out_sum and all mac_* outputs held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready=0, so no job overlap.
- Latency: job accepted on edge T; out_valid rises after edge T+N_TAPS. Throughput: one job per N_TAPS+2 cycles minimum.
- Arithmetic
  - Result equals bias + Σ A[k]·B[k] computed by the MAC, modulo 2^SUM_width.
  - Signed/unsigned interpretation governed solely by TC.
  - Wrap-around is silent; no saturation.
- in_valid asserted in RUN or DONE is ignored (in_ready=0); the source must hold the request.
- out_ready asserted while out_valid=0 has no effect.
- N_TAPS=1: RUN lasts one cycle.
- idx never exceeds N_TAPS-1; mac_select values ≥N_TAPS never driven.
- rst asserted in any state (including mid-RUN) returns to reset values on the next edge; the partial job is discarded and no out_valid pulse occurs.

Optional Feature:
- Macro: MAC_DOT_SEQUENCER_JOB_CNT_EN.
- Defined
  - Adds output job_cnt [15:0], reset 0.
  - Increments by 1 on each out_valid&&out_ready handshake, wrapping FFFF→0000.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Bench setup: mac_* connected to a behavioural A×B+C model.
- Unsigned: TC=0, A=[1,2,3,4,5], B=[1,1,1,1,1], bias=0 → out_valid 5 cycles after accept, out_sum=15; mac_select steps 0,1,2,3,4.
- Signed: TC=1, A=all 8'hFF (−1), B=all 8'h02, bias=100 → out_sum=90.
- Wrap: TC=0, A=B=all 8'hFF, bias=22'h3FFFFF → out_sum=(325125+4194303) mod 2^22=325124.
- Backpressure: out_ready low 3 cycles after result → out_valid and out_sum held, in_ready=0, second in_valid ignored until IDLE.
- Reset mid-job: rst pulsed when mac_select=2 → next cycle in_ready=1, out_valid=0, out_sum=0; following job A=[1,2,3,4,5], B=all 1, bias=0 gives 15.
- With MAC_DOT_SEQUENCER_JOB_CNT_EN: three completed jobs → job_cnt=3; reset → 0.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer driving a combinational 5-way muxed-A MAC, one tap per cycle.
// Optional job counter output enabled by defining MAC_DOT_SEQUENCER_JOB_CNT_EN.
module mac_dot_sequencer #(
    parameter int unsigned A_width   = 8,
    parameter int unsigned B_width   = 8,
    parameter int unsigned SUM_width = 22,
    parameter int unsigned N_TAPS    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [A_width*N_TAPS-1:0]   in_A,
    input  logic [B_width*N_TAPS-1:0]   in_B,
    input  logic [SUM_width-1:0]        in_bias,
    input  logic                        in_TC,
    output logic [2:0]                  mac_select,
    output logic [A_width*5-1:0]        mac_A,
    output logic [B_width-1:0]          mac_B,
    output logic [SUM_width-1:0]        mac_C,
    output logic                        mac_TC,
    input  logic [SUM_width-1:0]        mac_SUM,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SUM_width-1:0]        out_sum
`ifdef MAC_DOT_SEQUENCER_JOB_CNT_EN
    ,
    output logic [15:0]                 job_cnt
`endif
);

    localparam int unsigned MuxTaps = 5;
    localparam logic [2:0]  LastIdx = 3'(N_TAPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                       state_q, state_d;
    logic [2:0]                   idx_q, idx_d;
    logic [SUM_width-1:0]         acc_q, acc_d;
    logic [SUM_width-1:0]         out_sum_q, out_sum_d;
    logic [A_width*MuxTaps-1:0]   a_q, a_d;
    logic [B_width*N_TAPS-1:0]    b_q, b_d;
    logic                         tc_q, tc_d;
    logic                         out_valid_q, out_valid_d;
`ifdef MAC_DOT_SEQUENCER_JOB_CNT_EN
    logic [15:0]                  job_cnt_q, job_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tc_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tc_q        <= tc_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        a_d         = a_q;
        b_d         = b_q;
        tc_d        = tc_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        mac_select  = '0;
        mac_B       = '0;
        mac_C       = '0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Unused mux entries above N_TAPS are forced to zero.
                    a_d                       = '0;
                    a_d[A_width*N_TAPS-1:0]   = in_A;
                    b_d                       = in_B;
                    tc_d                      = in_TC;
                    acc_d                     = in_bias;
                    idx_d                     = '0;
                    state_d                   = StRun;
                end
            end
            StRun: begin
                mac_select = idx_q;
                mac_B      = b_q[B_width*idx_q +: B_width];
                mac_C      = acc_q;
                // On the last tap idx and acc freeze so the MAC inputs stay put through DONE.
                if (idx_q == LastIdx) begin
                    out_sum_d   = mac_SUM;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    acc_d = mac_SUM;
                    idx_d = idx_q + 3'd1;
                end
            end
            StDone: begin
                mac_select = idx_q;
                mac_B      = b_q[B_width*idx_q +: B_width];
                mac_C      = acc_q;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mac_A     = a_q;
    assign mac_TC    = tc_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

`ifdef MAC_DOT_SEQUENCER_JOB_CNT_EN
    always_comb begin
        job_cnt_d = job_cnt_q;
        if (out_valid_q && out_ready) begin
            job_cnt_d = job_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            job_cnt_q <= '0;
        end else begin
            job_cnt_q <= job_cnt_d;
        end
    end

    assign job_cnt = job_cnt_q;
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed self-checking bench for mac_dot_sequencer with a behavioural A*B+C MAC model.
module tb_mac_dot_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_A;
    logic [39:0] in_B;
    logic [21:0] in_bias;
    logic        in_TC;
    logic [2:0]  mac_select;
    logic [39:0] mac_A;
    logic [7:0]  mac_B;
    logic [21:0] mac_C;
    logic        mac_TC;
    logic [21:0] mac_SUM;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_sum;
`ifdef MAC_DOT_SEQUENCER_JOB_CNT_EN
    logic [15:0] job_cnt;
`endif

    int errors = 0;
    int checks = 0;

    mac_dot_sequencer #(
        .A_width  (8),
        .B_width  (8),
        .SUM_width(22),
        .N_TAPS   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_bias   (in_bias),
        .in_TC     (in_TC),
        .mac_select(mac_select),
        .mac_A     (mac_A),
        .mac_B     (mac_B),
        .mac_C     (mac_C),
        .mac_TC    (mac_TC),
        .mac_SUM   (mac_SUM),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef MAC_DOT_SEQUENCER_JOB_CNT_EN
        ,
        .job_cnt   (job_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: sign- or zero-extend operands, multiply and add modulo 2^22.
    logic [7:0]  m_a;
    logic [21:0] m_prod;
    always_comb begin
        m_a = 8'h00;
        if (mac_select < 3'd5) m_a = mac_A[int'(mac_select)*8 +: 8];
        if (mac_TC) m_prod = {{14{m_a[7]}}, m_a} * {{14{mac_B[7]}}, mac_B};
        else        m_prod = {14'h0, m_a} * {14'h0, mac_B};
        mac_SUM = m_prod + mac_C;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a job and returns 1ns after the accepting edge (state RUN, idx 0).
    task automatic start_job(input logic [39:0] a, input logic [39:0] b,
                             input logic [21:0] bias, input logic tc, output bit ok);
        int n = 0;
        in_A = a; in_B = b; in_bias = bias; in_TC = tc;
        while (!in_ready && n < 20) begin tick(); n++; end
        ok = in_ready;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin tick(); cyc++; end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 22'd0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b out_sum=%0d, want 1 0 0",
                     in_ready, out_valid, out_sum);
        end
        checks++;
        if (mac_select !== 3'd0 || mac_A !== 40'd0 || mac_B !== 8'd0 || mac_C !== 22'd0
            || mac_TC !== 1'b0) begin
            errors++;
            $display("FAIL reset_mac: sel=%0d A=%h B=%h C=%h TC=%b, want all 0",
                     mac_select, mac_A, mac_B, mac_C, mac_TC);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        bit ok;
        start_job(40'h05_04_03_02_01, 40'h01_01_01_01_01, 22'd0, 1'b0, ok);
        checks++;
        if (!ok || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_accept: ok=%b in_ready=%b, want 1 0", ok, in_ready);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mac_select !== 3'(k) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL unsigned_select%0d: sel=%0d out_valid=%b, want %0d 0",
                         k, mac_select, out_valid, k);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 22'd15) begin
            errors++;
            $display("FAIL unsigned_result: out_valid=%b out_sum=%0d, want 1 15",
                     out_valid, out_sum);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL unsigned_release: out_valid=%b in_ready=%b, want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_signed();
        bit ok;
        int cyc;
        start_job(40'hFF_FF_FF_FF_FF, 40'h02_02_02_02_02, 22'd100, 1'b1, ok);
        checks++;
        if (mac_TC !== 1'b1 || mac_B !== 8'h02) begin
            errors++;
            $display("FAIL signed_mac_inputs: TC=%b B=%h, want 1 02", mac_TC, mac_B);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out_sum !== 22'd90) begin
            errors++;
            $display("FAIL signed_result: latency=%0d out_sum=%0d, want 5 90", cyc, out_sum);
        end
        handshake();
    endtask

    task automatic test_wrap();
        bit ok;
        int cyc;
        start_job(40'hFF_FF_FF_FF_FF, 40'hFF_FF_FF_FF_FF, 22'h3FFFFF, 1'b0, ok);
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out_sum !== 22'd325124) begin
            errors++;
            $display("FAIL wrap_result: latency=%0d out_sum=%0d, want 5 325124", cyc, out_sum);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        // First job: 2*(1+2+3+4+5)+7 = 37.
        start_job(40'h05_04_03_02_01, 40'h02_02_02_02_02, 22'd7, 1'b0, ok);
        wait_valid(cyc);
        // Second request held during backpressure: 5*(2*3) = 30.
        in_A = 40'h02_02_02_02_02; in_B = 40'h03_03_03_03_03; in_bias = 22'd0; in_TC = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 22'd37 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: out_valid=%b out_sum=%0d in_ready=%b, want 1 37 0",
                         k, out_valid, out_sum, in_ready);
            end
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_idle: out_valid=%b in_ready=%b, want 0 1",
                     out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out_sum !== 22'd30) begin
            errors++;
            $display("FAIL backpressure_second: latency=%0d out_sum=%0d, want 5 30", cyc, out_sum);
        end
        handshake();
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        bit seen_valid = 1'b0;
        int cyc;
        start_job(40'h09_09_09_09_09, 40'h09_09_09_09_09, 22'd1, 1'b0, ok);
        tick();
        tick();
        checks++;
        if (mac_select !== 3'd2) begin
            errors++;
            $display("FAIL midreset_select: sel=%0d, want 2", mac_select);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 22'd0) begin
            errors++;
            $display("FAIL midreset_state: in_ready=%b out_valid=%b out_sum=%0d, want 1 0 0",
                     in_ready, out_valid, out_sum);
        end
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL midreset_no_pulse: out_valid seen=1, want 0");
        end
        start_job(40'h05_04_03_02_01, 40'h01_01_01_01_01, 22'd0, 1'b0, ok);
        wait_valid(cyc);
        checks++;
        if (cyc != 5 || out_sum !== 22'd15) begin
            errors++;
            $display("FAIL midreset_next_job: latency=%0d out_sum=%0d, want 5 15", cyc, out_sum);
        end
        handshake();
    endtask

`ifdef MAC_DOT_SEQUENCER_JOB_CNT_EN
    task automatic test_job_cnt();
        bit ok;
        int cyc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            start_job(40'h01_01_01_01_01, 40'h01_01_01_01_01, 22'd0, 1'b0, ok);
            wait_valid(cyc);
            handshake();
        end
        checks++;
        if (job_cnt !== 16'd3) begin
            errors++;
            $display("FAIL job_cnt_three: job_cnt=%0d, want 3", job_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (job_cnt !== 16'd0) begin
            errors++;
            $display("FAIL job_cnt_reset: job_cnt=%0d, want 0", job_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_A = '0; in_B = '0; in_bias = '0; in_TC = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_wrap();
        test_back_to_back();
        test_reset_mid_job();
`ifdef MAC_DOT_SEQUENCER_JOB_CNT_EN
        test_job_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
